// File: rtl/mmio_responder.sv
// I/O window responder beside data memory: LED register, synchronised switches, debounced button.
// Zero-latency combinational loads; stores and clear-on-read side effects commit on the rising clk edge.
module mmio_responder #(
    parameter logic [31:0] IO_BASE    = 32'hFFFF_FC00,
    parameter int          DEB_CYCLES = 20,
    parameter int          DEB_W      = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  length,
    input  logic        sign,
    input  logic [15:0] switches,
    input  logic        button,
    output logic        hit,
    output logic [31:0] dout,
    output logic [15:0] LED
);

    localparam logic [7:0]       OFF_LED  = 8'h60;
    localparam logic [7:0]       OFF_SW   = 8'h70;
    localparam logic [7:0]       OFF_BTN  = 8'h74;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic [15:0]      led_q;
    logic [15:0]      sw_s1;
    logic [15:0]      sw_s2;
    logic             btn_s1;
    logic             btn_s2;
    logic             deb_lvl;
    logic [DEB_W-1:0] deb_cnt;
    logic             evt_flag;
    logic [7:0]       press_cnt;

    logic [7:0]  reg_off;
    logic        btn_rd;
    logic        led_wr;
    logic        deb_diff;
    logic        deb_done;
    logic        deb_rise;
    logic [31:0] reg_val;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] rd_dat;

    // Registers are word-aligned; the low address bits only pick the lane.
    assign reg_off  = {addr[7:2], 2'b00};
    assign hit      = (addr[31:8] == IO_BASE[31:8]);
    assign btn_rd   = hit && MemRead && (reg_off == OFF_BTN);
    assign led_wr   = hit && MemWrite && (reg_off == OFF_LED);
    assign deb_diff = (btn_s2 != deb_lvl);
    assign deb_done = deb_diff && (deb_cnt == DEB_LAST);
    assign deb_rise = deb_done && !deb_lvl;
    assign LED      = led_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1  <= '0;
            sw_s2  <= '0;
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
        end else begin
            sw_s1  <= switches;
            sw_s2  <= sw_s1;
            btn_s1 <= button;
            btn_s2 <= btn_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            deb_lvl <= 1'b0;
            deb_cnt <= '0;
        end else if (!deb_diff) begin
            deb_cnt <= '0;
        end else if (deb_done) begin
            deb_lvl <= ~deb_lvl;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    // A new press outranks a simultaneous clear-on-read.
    always_ff @(posedge clk) begin
        if (rst) begin
            evt_flag  <= 1'b0;
            press_cnt <= '0;
        end else if (deb_rise) begin
            evt_flag  <= 1'b1;
            press_cnt <= press_cnt + 1'b1;
        end else if (btn_rd) begin
            evt_flag  <= 1'b0;
        end
    end

    // Byte stores choose the LED half by addr[0] alone, data always from din[7:0].
    always_ff @(posedge clk) begin
        if (rst) begin
            led_q <= '0;
        end else if (led_wr) begin
            if (length == 2'd0) begin
                if (addr[0]) led_q[15:8] <= din[7:0];
                else         led_q[7:0]  <= din[7:0];
            end else begin
                led_q <= din[15:0];
            end
        end
    end

    always_comb begin
        reg_val = '0;
        case (reg_off)
            OFF_LED: reg_val = {16'h0, led_q};
            OFF_SW:  reg_val = {16'h0, sw_s2};
            OFF_BTN: reg_val = {16'h0, press_cnt, 6'h0, evt_flag, deb_lvl};
            default: reg_val = '0;
        endcase
    end

    always_comb begin
        byte_lane = reg_val[7:0];
        case (addr[1:0])
            2'd0: byte_lane = reg_val[7:0];
            2'd1: byte_lane = reg_val[15:8];
            2'd2: byte_lane = reg_val[23:16];
            2'd3: byte_lane = reg_val[31:24];
            default: byte_lane = reg_val[7:0];
        endcase
        half_lane = addr[1] ? reg_val[31:16] : reg_val[15:0];
        rd_dat    = reg_val;
        case (length)
            2'd0: rd_dat = sign ? {{24{byte_lane[7]}}, byte_lane} : {24'h0, byte_lane};
            2'd1: rd_dat = sign ? {{16{half_lane[15]}}, half_lane} : {16'h0, half_lane};
            default: rd_dat = reg_val;
        endcase
    end

    assign dout = hit ? rd_dat : 32'h0;

endmodule

// File: tb/tb_mmio_responder.sv
// Randomised bench for mmio_responder against a cycle-level behavioural model of the register map.
module tb_mmio_responder;

    localparam int DEB = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] din;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  length;
    logic        sign;
    logic [15:0] switches;
    logic        button;
    logic        hit;
    logic [31:0] dout;
    logic [15:0] LED;

    int total = 0;
    int bad   = 0;

    // Model state
    logic [15:0] m_led = '0, m_sw1 = '0, m_sw2 = '0;
    logic        m_b1 = 1'b0, m_b2 = 1'b0, m_lvl = 1'b0, m_flag = 1'b0;
    int          m_run = 0;
    int          m_press = 0;

    always #5 clk = ~clk;

    mmio_responder dut (
        .clk(clk), .rst(rst), .addr(addr), .din(din), .MemRead(MemRead),
        .MemWrite(MemWrite), .length(length), .sign(sign), .switches(switches),
        .button(button), .hit(hit), .dout(dout), .LED(LED)
    );

    function automatic logic model_hit();
        return addr[31:8] == 24'hFFFFFC;
    endfunction

    function automatic logic [31:0] model_dout();
        logic [31:0] v;
        logic [31:0] lane;
        int          w;
        if (!model_hit()) return 32'h0;
        w = int'(addr[7:0]) & 'hFC;
        v = 0;
        if (w == 'h60) v = 32'(m_led);
        if (w == 'h70) v = 32'(m_sw2);
        if (w == 'h74) v = 32'(m_press * 256 + int'(m_flag) * 2 + int'(m_lvl));
        if (length == 2'd0) begin
            lane = (v >> (8 * int'(addr[1:0]))) & 32'hFF;
            if (sign && lane >= 128) lane = lane + 32'hFFFF_FF00;
        end else if (length == 2'd1) begin
            lane = (v >> (16 * int'(addr[1]))) & 32'hFFFF;
            if (sign && lane >= 32768) lane = lane + 32'hFFFF_0000;
        end else begin
            lane = v;
        end
        return lane;
    endfunction

    function automatic logic rise_next();
        return (m_b2 != m_lvl) && (m_run + 1 == DEB) && !m_lvl;
    endfunction

    // Advance the model by one edge with the current inputs, then advance the DUT.
    task automatic step();
        logic rise;
        int   w;
        if (rst) begin
            m_led = '0; m_sw1 = '0; m_sw2 = '0;
            m_b1 = 0; m_b2 = 0; m_lvl = 0; m_flag = 0; m_run = 0; m_press = 0;
        end else begin
            w = int'(addr[7:0]) & 'hFC;
            rise = 1'b0;
            if (m_b2 != m_lvl) begin
                m_run++;
                if (m_run == DEB) begin
                    m_lvl = ~m_lvl;
                    m_run = 0;
                    rise  = m_lvl;
                end
            end else begin
                m_run = 0;
            end
            if (rise) begin
                m_flag  = 1'b1;
                m_press = (m_press + 1) % 256;
            end else if (model_hit() && MemRead && w == 'h74) begin
                m_flag = 1'b0;
            end
            if (model_hit() && MemWrite && w == 'h60) begin
                if (length == 2'd0) begin
                    if (addr[0]) m_led[15:8] = din[7:0];
                    else         m_led[7:0]  = din[7:0];
                end else begin
                    m_led = din[15:0];
                end
            end
            m_b2 = m_b1; m_b1 = button;
            m_sw2 = m_sw1; m_sw1 = switches;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bus_idle();
        addr = 32'h0; din = 32'h0; MemRead = 0; MemWrite = 0; length = 2'd2; sign = 0;
    endtask

    task automatic test_reset();
        rst = 1; bus_idle(); switches = '0; button = 0;
        @(negedge clk);
        step(); step();
        rst = 0;
        #1;
        total++; if (LED !== 16'h0) begin bad++; $display("FAIL reset_led got=%h want=0000", LED); end
        addr = 32'hFFFF_FC74; #1;
        total++; if (dout !== 32'h0) begin bad++; $display("FAIL reset_btn got=%h want=00000000", dout); end
        addr = 32'hFFFF_FC70; #1;
        total++; if (dout !== 32'h0) begin bad++; $display("FAIL reset_sw got=%h want=00000000", dout); end
    endtask

    task automatic test_switches();
        logic [31:0] exp;
        switches = 16'h8001; addr = 32'hFFFF_FC70; length = 2'd2;
        step(); #1;
        total++; if (dout !== 32'h0) begin bad++; $display("FAIL sw_one_edge got=%h want=00000000", dout); end
        step(); #1;
        total++; if (dout !== 32'h0000_8001) begin bad++; $display("FAIL sw_word got=%h want=00008001", dout); end
        addr = 32'hFFFF_FC71; length = 2'd0; sign = 1; #1;
        total++; if (dout !== 32'hFFFF_FF80) begin bad++; $display("FAIL sw_byte_sx got=%h want=ffffff80", dout); end
        sign = 0; #1;
        total++; if (dout !== 32'h0000_0080) begin bad++; $display("FAIL sw_byte_zx got=%h want=00000080", dout); end
        for (int i = 0; i < 40; i++) begin
            switches = 16'($urandom);
            addr     = 32'hFFFF_FC70 + 32'($urandom_range(0, 3));
            length   = 2'($urandom_range(0, 3));
            sign     = 1'($urandom);
            #1; exp = model_dout();
            total++; if (dout !== exp) begin bad++; $display("FAIL sw_rand[%0d] got=%h want=%h", i, dout, exp); end
            step();
        end
        bus_idle();
    endtask

    task automatic test_glitch();
        int len;
        logic [31:0] exp;
        addr = 32'hFFFF_FC74; length = 2'd2;
        for (int k = 0; k < 5; k++) begin
            len = (k == 0) ? 10 : $urandom_range(1, DEB - 1);
            for (int c = 0; c < len + 25; c++) begin
                button = (c < len);
                #1; exp = model_dout();
                total++; if (dout !== exp) begin bad++; $display("FAIL glitch[%0d] got=%h want=%h", k, dout, exp); end
                step();
            end
        end
        #1;
        total++; if (dout !== 32'h0) begin bad++; $display("FAIL glitch_end got=%h want=00000000", dout); end
    endtask

    task automatic test_press();
        logic [31:0] exp;
        addr = 32'hFFFF_FC74; length = 2'd2; button = 1;
        for (int c = 0; c < 40; c++) begin
            #1; exp = model_dout();
            total++; if (dout !== exp) begin bad++; $display("FAIL press_c%0d got=%h want=%h", c, dout, exp); end
            step();
        end
        MemRead = 1; #1;
        total++; if (dout !== 32'h0000_0103) begin bad++; $display("FAIL btn_read1 got=%h want=00000103", dout); end
        step(); #1;
        total++; if (dout !== 32'h0000_0101) begin bad++; $display("FAIL btn_read2 got=%h want=00000101", dout); end
        step();
        MemRead = 0;
    endtask

    task automatic test_collision();
        logic found;
        logic [31:0] exp;
        addr = 32'hFFFF_FC74; length = 2'd2; button = 0;
        for (int c = 0; c < 30; c++) step();
        button = 1; found = 0;
        for (int c = 0; c < 60 && !found; c++) begin
            if (rise_next()) begin
                MemRead = 1; #1; exp = model_dout();
                total++; if (dout !== 32'h0000_0100 || exp !== 32'h0000_0100) begin
                    bad++; $display("FAIL collide_pre got=%h want=00000100", dout);
                end
                step();
                MemRead = 0; found = 1;
            end else begin
                step();
            end
        end
        total++; if (!found) begin bad++; $display("FAIL collide_timeout got=0 want=1"); end
        #1;
        total++; if (dout !== 32'h0000_0203) begin bad++; $display("FAIL collide_post got=%h want=00000203", dout); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp;
        rst = 1; button = 0; step(); rst = 0;
        addr = 32'hFFFF_FC74; length = 2'd2;
        for (int p = 0; p < 256; p++) begin
            button = 1; for (int c = 0; c < 24; c++) step();
            button = 0; for (int c = 0; c < 24; c++) step();
            if (p == 254) begin
                #1; exp = model_dout();
                total++; if (dout !== 32'h0000_FF02 || exp !== 32'h0000_FF02) begin
                    bad++; $display("FAIL wrap_255 got=%h want=0000ff02", dout);
                end
            end
        end
        #1;
        total++; if (dout !== 32'h0000_0002) begin bad++; $display("FAIL wrap_0 got=%h want=00000002", dout); end
    endtask

    task automatic test_led();
        logic [31:0] exp;
        logic [7:0]  offs [9];
        offs = '{8'h00, 8'h60, 8'h61, 8'h62, 8'h63, 8'h70, 8'h72, 8'h74, 8'h75};
        addr = 32'hFFFF_FC60; din = 32'h1234_ABCD; MemWrite = 1; length = 2'd2;
        step(); #1;
        total++; if (LED !== 16'hABCD) begin bad++; $display("FAIL led_word got=%h want=abcd", LED); end
        addr = 32'hFFFF_FC61; din = 32'h0000_005A; length = 2'd0;
        step(); #1;
        total++; if (LED !== 16'h5ACD) begin bad++; $display("FAIL led_byte got=%h want=5acd", LED); end
        addr = 32'hFFFF_FC70; din = 32'hFFFF_FFFF; length = 2'd2;
        step(); #1;
        total++; if (LED !== 16'h5ACD) begin bad++; $display("FAIL led_sw_store got=%h want=5acd", LED); end
        addr = 32'hFFFF_FB60; #1;
        total++; if (hit !== 1'b0 || dout !== 32'h0) begin bad++; $display("FAIL outside got=%b/%h want=0/00000000", hit, dout); end
        step(); #1;
        total++; if (LED !== 16'h5ACD) begin bad++; $display("FAIL led_outside got=%h want=5acd", LED); end
        for (int i = 0; i < 80; i++) begin
            addr     = ($urandom_range(0, 7) == 0) ? 32'($urandom) : {24'hFFFFFC, offs[$urandom_range(0, 8)]};
            din      = 32'($urandom);
            MemRead  = 1'($urandom);
            MemWrite = 1'($urandom);
            length   = 2'($urandom_range(0, 3));
            sign     = 1'($urandom);
            button   = ($urandom_range(0, 15) == 0) ? ~button : button;
            #1; exp = model_dout();
            total++; if (dout !== exp || hit !== model_hit() || LED !== m_led) begin
                bad++; $display("FAIL bus_rand[%0d] got=%h/%b/%h want=%h/%b/%h", i, dout, hit, LED, exp, model_hit(), m_led);
            end
            step();
        end
        bus_idle(); button = 0;
    endtask

    task automatic test_rst_mid();
        int n;
        logic [31:0] exp;
        addr = 32'hFFFF_FC74; length = 2'd2; button = 0;
        for (int c = 0; c < 30; c++) step();
        button = 1;
        for (int c = 0; c < 15; c++) step();
        rst = 1; step(); rst = 0;
        n = 0;
        for (int c = 1; c <= 60 && n == 0; c++) begin
            step(); #1; exp = model_dout();
            total++; if (dout !== exp) begin bad++; $display("FAIL rst_mid_c%0d got=%h want=%h", c, dout, exp); end
            if (dout[0] === 1'b1) n = c;
        end
        total++; if (n < DEB) begin bad++; $display("FAIL rst_mid_delay got=%0d want>=%0d", n, DEB); end
        total++; if (dout[15:8] !== 8'd1) begin bad++; $display("FAIL rst_mid_count got=%0d want=1", dout[15:8]); end
    endtask

    initial begin
        test_reset();
        test_switches();
        test_glitch();
        test_press();
        test_collision();
        test_led();
        test_wrap();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
